alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 16: datapath width in bits, minimum 8.
REQ-002 Parameter SP_RESET, default 0: stack-pointer value after reset.
REQ-003 Parameter SHAMT_W, default $clog2(WIDTH)+1: width of the magnitude used to saturate shift counts.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  block can accept a request.
REQ-008 op  input  3  operation: 0 add, 1 sub, 2 lsb, 3 const, 4 shift, 5 load-add, 6 push, 7 pass.
REQ-009 src  input  2  operand-B select: 0 in_b, 1 imm, 2 {0…,imm[2]}, 3 zero.
REQ-010 in_a, in_b, imm, load_val  input  WIDTH each  operands.
REQ-011 branch  input  1  request is a branch-if-zero.
REQ-012 out_valid  output  1  result registered and held.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 result  output  WIDTH  operation result.
REQ-015 branching  output  1  branch taken.
REQ-016 sp_addr  output  WIDTH  current stack pointer.

Function
REQ-017 Request accepted on a rising edge with in_valid && in_ready; all inputs sampled only at that edge.
REQ-018 in_ready SHALL be 1 only in state IDLE; FSM states IDLE, SHIFT, DONE.
REQ-019 IDLE→DONE on accept for every op except shift with non-zero amount; IDLE→SHIFT otherwise.
REQ-020 Single-cycle ops: out_valid rises in the cycle after accept (latency 1).
REQ-021 B = operand selected by src; all arithmetic is modulo 2^WIDTH, carry/borrow discarded.
REQ-022 add: A+B; sub: A−B; lsb: zero-extended A[0]; load-add: load_val+B; pass: A.
REQ-023 const: B[2:0] selects 0,1,9,48,95,144,−1,−96, sign-extended to WIDTH.
REQ-024 shift: B signed; B≥0 shifts A left, B<0 shifts A logically right by −B; magnitude saturates at WIDTH (result 0).
REQ-025 Shift executes one bit per cycle in SHIFT; magnitude k gives latency k+1; k=0 gives latency 1, result A.
REQ-026 push: sp_addr increments by 1 (wrapping at 2^WIDTH) at accept; result = new sp_addr.
REQ-027 branching = branch && (result==0), registered together with result.
REQ-028 DONE→IDLE on out_ready; out_valid, result and branching stay stable while out_valid && !out_ready.
REQ-029 out_ready while not in DONE has no effect.
REQ-030 in_ready SHALL be 0 in DONE even when out_ready is 1 (no same-cycle turnaround; throughput ≤ 1 request per 2 cycles).
REQ-031 Shift B = most-negative value SHALL saturate (right-shift result 0), with no overflow of the negation.

Reset
REQ-032 rst_n low SHALL immediately force state IDLE, in_ready 1, out_valid 0, result 0, branching 0, sp_addr SP_RESET, and the shift counter 0.
REQ-033 Reset asserted mid-shift or in DONE SHALL discard the request with no partial result ever presented.
REQ-034 First accept SHALL be possible on the first rising edge after rst_n rises.

Structure
REQ-035 Shared package alu_pkg SHALL hold the op and src encodings, the const table, and the FSM state type.
REQ-036 One sub-module, alu_shift_unit, SHALL hold the iterative shifter: load, step, done, and count-saturation logic.
REQ-037 Opcode and const decode SHALL be combinational in alu_seq; results SHALL be registered only in alu_seq.

Verification
REQ-038 WIDTH=16, add a=5 with src=1, imm=0xFFFB, branch=1 → result 0x0000, branching 1, out_valid one cycle after accept.
REQ-039 shift a=0x0001, src=1, imm=3 → result 0x0008 after 4 cycles; imm=0xFFF0 (−16) → result 0, 17 cycles.
REQ-040 Three consecutive push requests from reset (SP_RESET=0) → results 1,2,3; sp_addr 3; out_ready held 0 for 5 cycles keeps result 1 stable.
REQ-041 const src=1, imm=7 → result 0xFFA0; lsb a=0x0003 → result 0x0001, branching 0 with branch=1.
REQ-042 rst_n pulsed low during a 10-cycle shift → out_valid 0 immediately, in_ready 1, no result emitted; next add a=2, b=2 → 4.
REQ-043 WIDTH=32 build: sub a=0, b=1 → result 0xFFFFFFFF, branching 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: opcodes, operand-B selects,
// FSM states and the small constant table.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD   = 3'd0,
      OP_SUB   = 3'd1,
      OP_LSB   = 3'd2,
      OP_CONST = 3'd3,
      OP_SHIFT = 3'd4,
      OP_LDADD = 3'd5,
      OP_PUSH  = 3'd6,
      OP_PASS  = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      SRC_B    = 2'd0,
      SRC_IMM  = 2'd1,
      SRC_IMM2 = 2'd2,
      SRC_ZERO = 2'd3
   } src_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // 144 needs a ninth bit to stay positive before sign extension
   localparam int CONST_W = 9;

   function automatic logic signed [CONST_W-1:0] const_lookup(input logic [2:0] sel);
      logic signed [CONST_W-1:0] v;
      case (sel)
         3'd0:    v = 9'sd0;
         3'd1:    v = 9'sd1;
         3'd2:    v = 9'sd9;
         3'd3:    v = 9'sd48;
         3'd4:    v = 9'sd95;
         3'd5:    v = 9'sd144;
         3'd6:    v = -9'sd1;
         default: v = -9'sd96;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle of the sequential ALU; slave is the ALU side,
// master is the requester/consumer side.
interface alu_seq_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op;
   logic [1:0]       src;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [WIDTH-1:0] imm;
   logic [WIDTH-1:0] load_val;
   logic             branch;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             branching;
   logic [WIDTH-1:0] sp_addr;

   modport slave (
      input  in_valid, op, src, in_a, in_b, imm, load_val, branch, out_ready,
      output in_ready, out_valid, result, branching, sp_addr
   );

   modport master (
      output in_valid, op, src, in_a, in_b, imm, load_val, branch, out_ready,
      input  in_ready, out_valid, result, branching, sp_addr
   );
endinterface

// File: rtl/alu_shift_unit.sv
// Iterative one-bit-per-cycle shifter with saturated signed shift amount.
// B >= 0 shifts left, B < 0 shifts logically right by -B.
module alu_shift_unit #(
   parameter int WIDTH   = 16,
   parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic             step_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             zero_amt_o,
   output logic             last_o,
   output logic [WIDTH-1:0] next_val_o
);

   logic [WIDTH-1:0]   val_q, val_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   logic               left_q, left_d;
   logic [WIDTH:0]     mag_wide;
   logic [SHAMT_W-1:0] amt;

   // One extra bit keeps the negation of the most-negative B from overflowing
   assign mag_wide = b_i[WIDTH-1] ? ({1'b0, ~b_i} + (WIDTH+1)'(1)) : {1'b0, b_i};
   assign amt      = (mag_wide >= (WIDTH+1)'(WIDTH)) ? SHAMT_W'(WIDTH)
                                                     : mag_wide[SHAMT_W-1:0];

   assign zero_amt_o = (amt == '0);
   assign last_o     = (cnt_q == SHAMT_W'(1));
   assign next_val_o = left_q ? (val_q << 1) : (val_q >> 1);

   always_comb begin
      val_d  = val_q;
      cnt_d  = cnt_q;
      left_d = left_q;
      if (load_i) begin
         val_d  = a_i;
         cnt_d  = amt;
         left_d = ~b_i[WIDTH-1];
      end else if (step_i && cnt_q != '0) begin
         val_d = next_val_o;
         cnt_d = cnt_q - SHAMT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         val_q  <= '0;
         cnt_q  <= '0;
         left_q <= 1'b0;
      end else begin
         val_q  <= val_d;
         cnt_q  <= cnt_d;
         left_q <= left_d;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: accepts one request in IDLE, computes single-cycle ops
// directly or walks the shifter, then holds the result until consumed.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int SP_RESET = 0,
   parameter int SHAMT_W  = $clog2(WIDTH) + 1
) (
   input  logic       clk,
   input  logic       rst_n,
   alu_seq_if.slave   bus
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] sp_q, sp_d;
   logic             branching_q, branching_d;
   logic             branch_q, branch_d;

   op_e              op;
   src_e             src;
   logic             accept;
   logic [WIDTH-1:0] b_sel;
   logic [WIDTH-1:0] op_res;
   logic [WIDTH-1:0] sp_inc;
   logic signed [WIDTH+CONST_W-1:0] const_ext;

   logic             sh_load, sh_step, sh_zero, sh_last;
   logic [WIDTH-1:0] sh_next;

   assign op     = op_e'(bus.op);
   assign src    = src_e'(bus.src);
   assign accept = bus.in_valid && (state_q == ST_IDLE);
   assign sp_inc = sp_q + WIDTH'(1);

   always_comb begin
      b_sel = '0;
      case (src)
         SRC_B:    b_sel = bus.in_b;
         SRC_IMM:  b_sel = bus.imm;
         SRC_IMM2: b_sel = {{(WIDTH-1){1'b0}}, bus.imm[2]};
         default:  b_sel = '0;
      endcase
   end

   // Sign-extend via a wide signed temporary so WIDTH below 9 still works
   assign const_ext = const_lookup(b_sel[2:0]);

   always_comb begin
      op_res = bus.in_a;
      case (op)
         OP_ADD:   op_res = bus.in_a + b_sel;
         OP_SUB:   op_res = bus.in_a - b_sel;
         OP_LSB:   op_res = {{(WIDTH-1){1'b0}}, bus.in_a[0]};
         OP_CONST: op_res = const_ext[WIDTH-1:0];
         OP_SHIFT: op_res = bus.in_a;
         OP_LDADD: op_res = bus.load_val + b_sel;
         OP_PUSH:  op_res = sp_inc;
         default:  op_res = bus.in_a;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      result_d    = result_q;
      branching_d = branching_q;
      branch_d    = branch_q;
      sp_d        = sp_q;
      sh_load     = 1'b0;
      sh_step     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               branch_d = bus.branch;
               if (op == OP_PUSH) sp_d = sp_inc;
               if (op == OP_SHIFT && !sh_zero) begin
                  sh_load = 1'b1;
                  state_d = ST_SHIFT;
               end else begin
                  result_d    = op_res;
                  branching_d = bus.branch && (op_res == '0);
                  state_d     = ST_DONE;
               end
            end
         end
         ST_SHIFT: begin
            sh_step = 1'b1;
            if (sh_last) begin
               result_d    = sh_next;
               branching_d = branch_q && (sh_next == '0);
               state_d     = ST_DONE;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         result_q    <= '0;
         branching_q <= 1'b0;
         branch_q    <= 1'b0;
         sp_q        <= WIDTH'(SP_RESET);
      end else begin
         state_q     <= state_d;
         result_q    <= result_d;
         branching_q <= branching_d;
         branch_q    <= branch_d;
         sp_q        <= sp_d;
      end
   end

   alu_shift_unit #(
      .WIDTH   (WIDTH),
      .SHAMT_W (SHAMT_W)
   ) u_shift (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (sh_load),
      .step_i     (sh_step),
      .a_i        (bus.in_a),
      .b_i        (b_sel),
      .zero_amt_o (sh_zero),
      .last_o     (sh_last),
      .next_val_o (sh_next)
   );

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.result    = result_q;
   assign bus.branching = branching_q;
   assign bus.sp_addr   = sp_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized and directed bench for alu_seq against a plain-arithmetic model.
module tb_alu_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_seq_if #(.WIDTH(16)) bus16 ();
   alu_seq_if #(.WIDTH(32)) bus32 ();

   alu_seq #(.WIDTH(16), .SP_RESET(0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus16.slave)
   );

   alu_seq #(.WIDTH(32), .SP_RESET(0)) dut32 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus32.slave)
   );

   int n_tests = 0;
   int n_fail  = 0;
   logic [15:0] m_sp = '0;
   logic [15:0] obs_res;
   logic        obs_br;
   int          obs_lat;
   int          ctab [8] = '{0, 1, 9, 48, 95, 144, -1, -96};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: result, branch flag and latency from the operation rules
   task automatic model(input logic [2:0] op, input logic [1:0] src,
                        input logic [15:0] a, b, imm, lv, input logic br,
                        output logic [15:0] res, output logic brf, output int lat);
      logic [15:0] bb;
      int sb, mag;
      case (src)
         2'd0:    bb = b;
         2'd1:    bb = imm;
         2'd2:    bb = {15'b0, imm[2]};
         default: bb = 16'h0;
      endcase
      lat = 1;
      case (op)
         3'd0: res = a + bb;
         3'd1: res = a - bb;
         3'd2: res = {15'b0, a[0]};
         3'd3: res = 16'(ctab[bb[2:0]]);
         3'd4: begin
            sb  = int'($signed(bb));
            mag = (sb < 0) ? -sb : sb;
            if (mag > 16) mag = 16;
            if (mag >= 16)   res = 16'h0;
            else if (sb >= 0) res = a << mag;
            else              res = a >> mag;
            lat = mag + 1;
         end
         3'd5: res = lv + bb;
         3'd6: begin
            m_sp = m_sp + 16'd1;
            res  = m_sp;
         end
         default: res = a;
      endcase
      brf = br && (res == 16'h0);
   endtask

   task automatic run_req(input string tag, input logic [2:0] op, input logic [1:0] src,
                          input logic [15:0] a, b, imm, lv, input logic br, input int hold);
      logic [15:0] eres;
      logic        ebr;
      int          elat, lat;
      model(op, src, a, b, imm, lv, br, eres, ebr, elat);
      @(negedge clk);
      chk({tag, ".in_ready"}, 32'(bus16.in_ready), 32'd1);
      bus16.op = op; bus16.src = src; bus16.in_a = a; bus16.in_b = b;
      bus16.imm = imm; bus16.load_val = lv; bus16.branch = br;
      bus16.in_valid = 1'b1;
      @(posedge clk);
      #1 bus16.in_valid = 1'b0;
      lat = 1;
      @(negedge clk);
      while (!bus16.out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      obs_res = bus16.result;
      obs_br  = bus16.branching;
      obs_lat = lat;
      chk({tag, ".lat"}, 32'(lat), 32'(elat));
      chk({tag, ".result"}, 32'(bus16.result), 32'(eres));
      chk({tag, ".branching"}, 32'(bus16.branching), 32'(ebr));
      chk({tag, ".sp_addr"}, 32'(bus16.sp_addr), 32'(m_sp));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({tag, ".hold_valid"}, 32'(bus16.out_valid), 32'd1);
         chk({tag, ".hold_result"}, 32'(bus16.result), 32'(eres));
         chk({tag, ".hold_br"}, 32'(bus16.branching), 32'(ebr));
      end
      bus16.out_ready = 1'b1;
      #1 chk({tag, ".no_turnaround"}, 32'(bus16.in_ready), 32'd0);
      @(posedge clk);
      #1 bus16.out_ready = 1'b0;
      @(negedge clk);
      chk({tag, ".drained"}, 32'(bus16.out_valid), 32'd0);
   endtask

   initial begin
      logic [2:0]  r_op;
      logic [1:0]  r_src;
      logic [15:0] r_imm;
      int          seen;

      bus16.in_valid = 0; bus16.op = 0; bus16.src = 0; bus16.in_a = 0; bus16.in_b = 0;
      bus16.imm = 0; bus16.load_val = 0; bus16.branch = 0; bus16.out_ready = 0;
      bus32.in_valid = 0; bus32.op = 0; bus32.src = 0; bus32.in_a = 0; bus32.in_b = 0;
      bus32.imm = 0; bus32.load_val = 0; bus32.branch = 0; bus32.out_ready = 0;

      repeat (3) @(negedge clk);
      chk("rst.in_ready", 32'(bus16.in_ready), 32'd1);
      chk("rst.out_valid", 32'(bus16.out_valid), 32'd0);
      chk("rst.result", 32'(bus16.result), 32'd0);
      chk("rst.branching", 32'(bus16.branching), 32'd0);
      chk("rst.sp_addr", 32'(bus16.sp_addr), 32'd0);
      rst_n = 1'b1;

      // Pushes straight out of reset, first one back-pressured
      run_req("push1", 3'd6, 2'd0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 5);
      chk("push1.val", 32'(obs_res), 32'd1);
      run_req("push2", 3'd6, 2'd0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 0);
      chk("push2.val", 32'(obs_res), 32'd2);
      run_req("push3", 3'd6, 2'd0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 0);
      chk("push3.val", 32'(obs_res), 32'd3);
      chk("push3.sp", 32'(bus16.sp_addr), 32'd3);

      run_req("add_zero", 3'd0, 2'd1, 16'd5, 16'h0, 16'hFFFB, 16'h0, 1'b1, 1);
      chk("add_zero.val", 32'(obs_res), 32'h0);
      chk("add_zero.br", 32'(obs_br), 32'd1);
      chk("add_zero.lat", 32'(obs_lat), 32'd1);
      run_req("shl3", 3'd4, 2'd1, 16'h0001, 16'h0, 16'd3, 16'h0, 1'b0, 0);
      chk("shl3.val", 32'(obs_res), 32'h0008);
      chk("shl3.lat", 32'(obs_lat), 32'd4);
      run_req("shr16", 3'd4, 2'd1, 16'h0001, 16'h0, 16'hFFF0, 16'h0, 1'b0, 0);
      chk("shr16.val", 32'(obs_res), 32'h0);
      chk("shr16.lat", 32'(obs_lat), 32'd17);
      run_req("shr_minneg", 3'd4, 2'd1, 16'hFFFF, 16'h0, 16'h8000, 16'h0, 1'b1, 0);
      run_req("shl_big", 3'd4, 2'd0, 16'hFFFF, 16'd300, 16'h0, 16'h0, 1'b0, 0);
      run_req("shift0", 3'd4, 2'd3, 16'h1234, 16'h0, 16'h0, 16'h0, 1'b0, 0);
      run_req("const7", 3'd3, 2'd1, 16'h0, 16'h0, 16'd7, 16'h0, 1'b0, 0);
      chk("const7.val", 32'(obs_res), 32'hFFA0);
      run_req("const5", 3'd3, 2'd1, 16'h0, 16'h0, 16'd5, 16'h0, 1'b0, 0);
      run_req("lsb", 3'd2, 2'd0, 16'h0003, 16'h0, 16'h0, 16'h0, 1'b1, 0);
      chk("lsb.val", 32'(obs_res), 32'h0001);
      chk("lsb.br", 32'(obs_br), 32'd0);
      run_req("ldadd_imm2", 3'd5, 2'd2, 16'h0, 16'h0, 16'h0004, 16'h00FF, 1'b0, 0);

      // Reset in the middle of a 10-cycle shift
      @(negedge clk);
      bus16.op = 3'd4; bus16.src = 2'd1; bus16.in_a = 16'h0001; bus16.imm = 16'd10;
      bus16.branch = 1'b0; bus16.in_valid = 1'b1;
      @(posedge clk);
      #1 bus16.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      m_sp  = 16'h0;
      #1;
      chk("midrst.out_valid", 32'(bus16.out_valid), 32'd0);
      chk("midrst.in_ready", 32'(bus16.in_ready), 32'd1);
      chk("midrst.result", 32'(bus16.result), 32'd0);
      chk("midrst.sp_addr", 32'(bus16.sp_addr), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (15) begin
         @(negedge clk);
         if (bus16.out_valid) seen++;
      end
      chk("midrst.no_result", 32'(seen), 32'd0);
      run_req("add22", 3'd0, 2'd0, 16'd2, 16'd2, 16'h0, 16'h0, 1'b0, 0);
      chk("add22.val", 32'(obs_res), 32'd4);

      for (int n = 0; n < 150; n++) begin
         r_op  = 3'($urandom_range(0, 7));
         r_src = 2'($urandom_range(0, 3));
         r_imm = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($signed($urandom_range(0, 40)) - 20);
         run_req("rand", r_op, r_src, 16'($urandom), 16'($urandom), r_imm, 16'($urandom),
                 1'($urandom), int'($urandom_range(0, 2)));
      end

      // Wide build: borrow wraps to all ones
      @(negedge clk);
      bus32.op = 3'd1; bus32.src = 2'd0; bus32.in_a = 32'd0; bus32.in_b = 32'd1;
      bus32.branch = 1'b1; bus32.in_valid = 1'b1;
      @(posedge clk);
      #1 bus32.in_valid = 1'b0;
      @(negedge clk);
      chk("w32.out_valid", 32'(bus32.out_valid), 32'd1);
      chk("w32.result", bus32.result, 32'hFFFF_FFFF);
      chk("w32.branching", 32'(bus32.branching), 32'd0);
      bus32.out_ready = 1'b1;
      @(posedge clk);
      #1 bus32.out_ready = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
